// File: rtl/dbg_mem_loader_pkg.sv
// Shared types and protocol constants for the debug memory loader.
// Frame bytes, response codes, FSM states and the sticky error flags.
package dbg_mem_loader_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_CNT,
      S_DATA,
      S_WR,
      S_RD,
      S_CHK,
      S_RESP
   } state_t;

   localparam logic [7:0] SYNC       = 8'hA5;
   localparam logic [7:0] CMD_WRITE  = 8'h01;
   localparam logic [7:0] CMD_VERIFY = 8'h02;
   localparam logic [7:0] CMD_RUN    = 8'h03;
   localparam logic [7:0] CMD_HALT   = 8'h04;

   typedef logic [7:0] resp_t;
   localparam resp_t ACK = 8'h06;
   localparam resp_t NAK = 8'h15;

   typedef struct packed {
      logic checksum;
      logic verify;
   } err_t;

   // States in which the loader is waiting on the host byte stream.
   function automatic logic rx_state(input state_t s);
      return (s == S_IDLE) || (s == S_CMD) || (s == S_ADDR) ||
             (s == S_CNT) || (s == S_DATA) || (s == S_CHK);
   endfunction

   // States in which a stalled host counts toward the inter-byte timeout.
   function automatic logic tmo_state(input state_t s);
      return (s == S_CMD) || (s == S_ADDR) || (s == S_CNT) ||
             (s == S_DATA) || (s == S_CHK);
   endfunction

endpackage

// File: rtl/dbg_word_pack.sv
// Little-endian byte-to-word packer: a byte counter plus right-shifting register.
// word_nxt is the completed word in the same cycle that done pulses.
module dbg_word_pack #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              byte_vld,
   input  logic [7:0]        byte_in,
   output logic [DATA_W-1:0] word_nxt,
   output logic              done
);

   localparam int NB = DATA_W / 8;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;

   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] sr_q, sr_d;

   always_comb begin
      word_nxt = {byte_in, sr_q[DATA_W-1:8]};
      done     = byte_vld && (cnt_q == CW'(NB - 1));
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      if (clr) begin
         cnt_d = '0;
      end else if (byte_vld) begin
         cnt_d = done ? '0 : cnt_q + 1'b1;
         sr_d  = word_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   // Shift register is pure datapath; the counter alone decides framing.
   always_ff @(posedge clk) begin
      sr_q <= sr_d;
   end

endmodule

// File: rtl/dbg_mem_loader.sv
// Byte-stream command parser driving the debug memory port of the CPU.
// Loads/verifies memory while holding the CPU in reset; RUN/HALT control cpu_n_reset.
module dbg_mem_loader
   import dbg_mem_loader_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   output logic                rx_ready,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                dbg_mem_op,
   output logic [DATA_W/8-1:0] dbg_wren,
   output logic [ADDR_W-1:0]   dbg_adr,
   output logic [DATA_W-1:0]   dbg_do,
   input  logic [DATA_W-1:0]   dbg_di,
   input  logic                dbg_ack,
   output logic                cpu_n_reset,
   output logic                busy,
   output logic                err_checksum,
   output logic                err_verify
);

   localparam int NB = DATA_W / 8;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] do_q, do_d;
   logic              mem_op_q, mem_op_d;
   logic [NB-1:0]     wren_q, wren_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [7:0]        chk_q, chk_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_valid_q, tx_valid_d;
   logic              cpu_q, cpu_d;
   err_t              err_q, err_d;
   logic [7:0]        cmd_q, cmd_d;

   logic              accept, pack_clr;
   logic              addr_done, cnt_done, data_done;
   logic [ADDR_W-1:0] addr_word;
   logic [15:0]       cnt_word;
   logic [DATA_W-1:0] data_word;
   logic              resp_go, word_done, timed_out;
   resp_t             resp_byte;

   assign rx_ready = rx_state(state_q);
   assign accept   = rx_valid && rx_ready;
   assign pack_clr = accept && (state_q == S_IDLE) && (rx_data == SYNC);

   dbg_word_pack #(.DATA_W(ADDR_W)) u_addr_pack (
      .clk(clk), .reset(reset), .clr(pack_clr),
      .byte_vld(accept && (state_q == S_ADDR)), .byte_in(rx_data),
      .word_nxt(addr_word), .done(addr_done)
   );

   dbg_word_pack #(.DATA_W(16)) u_cnt_pack (
      .clk(clk), .reset(reset), .clr(pack_clr),
      .byte_vld(accept && (state_q == S_CNT)), .byte_in(rx_data),
      .word_nxt(cnt_word), .done(cnt_done)
   );

   dbg_word_pack #(.DATA_W(DATA_W)) u_data_pack (
      .clk(clk), .reset(reset), .clr(pack_clr),
      .byte_vld(accept && (state_q == S_DATA)), .byte_in(rx_data),
      .word_nxt(data_word), .done(data_done)
   );

   always_comb begin
      state_d    = state_q;
      adr_d      = adr_q;
      do_d       = do_q;
      mem_op_d   = mem_op_q;
      wren_d     = wren_q;
      cnt_d      = cnt_q;
      chk_d      = chk_q;
      tmo_d      = '0;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      cpu_d      = cpu_q;
      err_d      = err_q;
      cmd_d      = cmd_q;
      resp_go    = 1'b0;
      resp_byte  = NAK;
      word_done  = 1'b0;
      timed_out  = 1'b0;

      if (tmo_state(state_q) && !accept) begin
         tmo_d     = tmo_q + 1'b1;
         timed_out = (tmo_q == TW'(TIMEOUT_CYC - 1));
      end

      case (state_q)
         S_IDLE: begin
            if (pack_clr) begin
               state_d = S_CMD;
               err_d   = '0;
               chk_d   = '0;
            end
         end
         S_CMD: begin
            if (accept) begin
               cmd_d = rx_data;
               if ((rx_data == CMD_WRITE) || (rx_data == CMD_VERIFY)) begin
                  if (cpu_q) resp_go = 1'b1;
                  else       state_d = S_ADDR;
               end else if ((rx_data == CMD_RUN) || (rx_data == CMD_HALT)) begin
                  resp_go   = 1'b1;
                  resp_byte = ACK;
               end else begin
                  resp_go = 1'b1;
               end
            end
         end
         S_ADDR: begin
            if (addr_done) begin
               adr_d   = addr_word;
               state_d = S_CNT;
            end
         end
         S_CNT: begin
            if (cnt_done) begin
               cnt_d   = cnt_word;
               state_d = (cnt_word == 16'd0) ? S_CHK : S_DATA;
            end
         end
         S_DATA: begin
            if (accept) chk_d = chk_q ^ rx_data;
            if (data_done) begin
               do_d     = data_word;
               mem_op_d = 1'b1;
               wren_d   = '1;
               state_d  = S_WR;
            end
         end
         S_WR: begin
            if (mem_op_q && dbg_ack) begin
               mem_op_d = 1'b0;
               wren_d   = '0;
               if (cmd_q == CMD_VERIFY) state_d = S_RD;
               else                     word_done = 1'b1;
            end
         end
         S_RD: begin
            // First RD cycle is the mandatory idle gap after the write ack.
            if (!mem_op_q) begin
               mem_op_d = 1'b1;
            end else if (dbg_ack) begin
               mem_op_d = 1'b0;
               if (dbg_di != do_q) err_d.verify = 1'b1;
               word_done = 1'b1;
            end
         end
         S_CHK: begin
            if (accept) begin
               if (rx_data != chk_q) err_d.checksum = 1'b1;
               resp_go   = 1'b1;
               resp_byte = ((rx_data != chk_q) || err_q.verify) ? NAK : ACK;
            end
         end
         S_RESP: begin
            if (tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = S_IDLE;
               if (tx_data_q == ACK) begin
                  if (cmd_q == CMD_RUN)  cpu_d = 1'b1;
                  if (cmd_q == CMD_HALT) cpu_d = 1'b0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (word_done) begin
         adr_d   = adr_q + ADDR_W'(NB);
         cnt_d   = cnt_q - 1'b1;
         state_d = (cnt_q == 16'd1) ? S_CHK : S_DATA;
      end

      if (timed_out) begin
         resp_go   = 1'b1;
         resp_byte = NAK;
         cmd_d     = '0;
      end

      if (resp_go) begin
         state_d    = S_RESP;
         tx_data_d  = resp_byte;
         tx_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         adr_q      <= '0;
         do_q       <= '0;
         mem_op_q   <= 1'b0;
         wren_q     <= '0;
         cnt_q      <= '0;
         chk_q      <= '0;
         tmo_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         cpu_q      <= 1'b0;
         err_q      <= '0;
         cmd_q      <= '0;
      end else begin
         state_q    <= state_d;
         adr_q      <= adr_d;
         do_q       <= do_d;
         mem_op_q   <= mem_op_d;
         wren_q     <= wren_d;
         cnt_q      <= cnt_d;
         chk_q      <= chk_d;
         tmo_q      <= tmo_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         cpu_q      <= cpu_d;
         err_q      <= err_d;
         cmd_q      <= cmd_d;
      end
   end

   assign tx_data      = tx_data_q;
   assign tx_valid     = tx_valid_q;
   assign dbg_mem_op   = mem_op_q;
   assign dbg_wren     = wren_q;
   assign dbg_adr      = adr_q;
   assign dbg_do       = do_q;
   assign cpu_n_reset  = cpu_q;
   assign busy         = (state_q != S_IDLE);
   assign err_checksum = err_q.checksum;
   assign err_verify   = err_q.verify;

endmodule

// File: tb/tb_dbg_mem_loader.sv
// Directed bench for dbg_mem_loader: a memory responder with varying ack latency
// and host-side frame tasks; each scenario task checks its own expected values.
module tb_dbg_mem_loader;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int TMO    = 50;

   logic              clk = 1'b0;
   logic              reset;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              dbg_mem_op;
   logic [3:0]        dbg_wren;
   logic [ADDR_W-1:0] dbg_adr;
   logic [DATA_W-1:0] dbg_do;
   logic [DATA_W-1:0] dbg_di;
   logic              dbg_ack;
   logic              cpu_n_reset;
   logic              busy;
   logic              err_checksum;
   logic              err_verify;

   dbg_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .reset(reset),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .dbg_mem_op(dbg_mem_op), .dbg_wren(dbg_wren), .dbg_adr(dbg_adr),
      .dbg_do(dbg_do), .dbg_di(dbg_di), .dbg_ack(dbg_ack),
      .cpu_n_reset(cpu_n_reset), .busy(busy),
      .err_checksum(err_checksum), .err_verify(err_verify)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] prog [3] = '{32'h000107b7, 32'h0007a023, 32'h0000006f};

   // Memory responder state
   logic [31:0] mem [logic [31:0]];
   logic [31:0] wr_adr [$];
   logic [31:0] wr_dat [$];
   int          rd_n      = 0;
   int          wren_bad  = 0;
   int          ack_dly   = 0;
   int          wcnt      = 0;
   bit          ack_block = 1'b0;
   bit          flip_en   = 1'b0;

   always @(negedge clk) begin
      dbg_ack = 1'b0;
      if (dbg_mem_op && !ack_block) begin
         if (wcnt >= ack_dly) begin
            dbg_ack = 1'b1;
            wcnt    = 0;
            ack_dly = (ack_dly + 1) % 5;
            if (dbg_wren != 4'h0) begin
               if (dbg_wren != 4'hF) wren_bad++;
               mem[dbg_adr] = dbg_do;
               wr_adr.push_back(dbg_adr);
               wr_dat.push_back(dbg_do);
            end else begin
               rd_n++;
               dbg_di = mem.exists(dbg_adr) ? mem[dbg_adr] : 32'h0;
               if (flip_en && dbg_adr == 32'h0002_0004) dbg_di = dbg_di ^ 32'h1;
            end
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      bit done = 1'b0;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if (rx_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
            break;
         end
         @(negedge clk);
      end
      rx_valid = 1'b0;
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL rx_accept byte %02h not taken, rx_ready=%b required 1", b, rx_ready);
      end
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [31:0] adr,
                             input int cnt, input logic [7:0] chk, input bit with_chk);
      send_byte(8'hA5);
      send_byte(cmd);
      for (int i = 0; i < 4; i++) send_byte(adr[8*i +: 8]);
      send_byte(cnt[7:0]);
      send_byte(cnt[15:8]);
      for (int w = 0; w < cnt; w++)
         for (int b = 0; b < 4; b++) send_byte(prog[w][8*b +: 8]);
      if (with_chk) send_byte(chk);
   endtask

   // Waits for a response byte and completes the handshake; returns #1 after that edge.
   task automatic wait_resp(output logic [7:0] b, output bit ok);
      ok = 1'b0;
      b  = 8'hxx;
      tx_ready = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (tx_valid) begin
            ok = 1'b1;
            b  = tx_data;
            break;
         end
      end
      if (ok) begin
         @(posedge clk);
         #1;
      end
      tx_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      n_tests++; if (cpu_n_reset !== 1'b0) begin n_fail++; $display("FAIL rst_cpu got %b want 0", cpu_n_reset); end
      n_tests++; if (dbg_mem_op !== 1'b0) begin n_fail++; $display("FAIL rst_memop got %b want 0", dbg_mem_op); end
      n_tests++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rxready got %b want 1", rx_ready); end
      n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_txvalid got %b want 0", tx_valid); end
      n_tests++; if ({busy, dbg_wren, dbg_adr} !== 37'h0) begin n_fail++; $display("FAIL rst_regs got busy=%b wren=%h adr=%h want 0", busy, dbg_wren, dbg_adr); end
      reset = 1'b0;
      send_byte(8'h00);
      send_byte(8'h55);
      repeat (3) @(negedge clk);
      n_tests++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_junk got busy=%b tx_valid=%b want 0/0", busy, tx_valid); end
   endtask

   task automatic test_write(input logic [7:0] chk, input logic [7:0] exp_resp,
                             input logic exp_err, input string nm);
      int base = wr_adr.size();
      int wb   = wren_bad;
      logic [7:0] b;
      bit ok;
      send_frame(8'h01, 32'h0002_0000, 3, chk, 1'b1);
      wait_resp(b, ok);
      n_tests++; if (!ok || b !== exp_resp) begin n_fail++; $display("FAIL %s_resp got %h (seen=%b) want %h", nm, b, ok, exp_resp); end
      n_tests++; if (wr_adr.size() - base != 3) begin n_fail++; $display("FAIL %s_nwr got %0d want 3", nm, wr_adr.size() - base); end
      for (int i = 0; i < 3; i++) begin
         if (base + i < wr_adr.size()) begin
            n_tests++;
            if (wr_adr[base+i] !== 32'h0002_0000 + 4*i || wr_dat[base+i] !== prog[i]) begin
               n_fail++;
               $display("FAIL %s_word%0d got %h@%h want %h@%h", nm, i, wr_dat[base+i], wr_adr[base+i], prog[i], 32'h0002_0000 + 4*i);
            end
         end
      end
      n_tests++; if (wren_bad != wb) begin n_fail++; $display("FAIL %s_wren bad count %0d want 0", nm, wren_bad - wb); end
      n_tests++; if (err_checksum !== exp_err || err_verify !== 1'b0) begin n_fail++; $display("FAIL %s_err got chk=%b ver=%b want %b/0", nm, err_checksum, err_verify, exp_err); end
   endtask

   task automatic test_sync_clears;
      logic [7:0] b;
      bit ok;
      send_byte(8'hA5);
      @(negedge clk);
      n_tests++; if (err_checksum !== 1'b0) begin n_fail++; $display("FAIL sync_clear got %b want 0", err_checksum); end
      send_byte(8'h04);
      wait_resp(b, ok);
      n_tests++; if (!ok || b !== 8'h06) begin n_fail++; $display("FAIL halt_resp got %h want 06", b); end
   endtask

   task automatic test_count_zero;
      int base = wr_adr.size();
      logic [7:0] b;
      bit ok;
      send_frame(8'h01, 32'h0004_0000, 0, 8'h00, 1'b1);
      wait_resp(b, ok);
      n_tests++; if (!ok || b !== 8'h06) begin n_fail++; $display("FAIL cnt0_resp got %h want 06", b); end
      n_tests++; if (wr_adr.size() != base) begin n_fail++; $display("FAIL cnt0_nwr got %0d want 0", wr_adr.size() - base); end
   endtask

   task automatic test_verify;
      int base = wr_adr.size();
      int rb   = rd_n;
      logic [7:0] b;
      bit ok;
      flip_en = 1'b1;
      send_frame(8'h02, 32'h0002_0000, 3, 8'h5A, 1'b1);
      wait_resp(b, ok);
      flip_en = 1'b0;
      n_tests++; if (!ok || b !== 8'h15) begin n_fail++; $display("FAIL ver_resp got %h want 15", b); end
      n_tests++; if (wr_adr.size() - base != 3) begin n_fail++; $display("FAIL ver_nwr got %0d want 3", wr_adr.size() - base); end
      n_tests++; if (rd_n - rb != 3) begin n_fail++; $display("FAIL ver_nrd got %0d want 3", rd_n - rb); end
      n_tests++; if (err_verify !== 1'b1 || err_checksum !== 1'b0) begin n_fail++; $display("FAIL ver_err got ver=%b chk=%b want 1/0", err_verify, err_checksum); end
   endtask

   task automatic test_run_halt;
      int base = wr_adr.size();
      logic [7:0] b;
      bit ok;
      send_byte(8'hA5);
      send_byte(8'h03);
      wait_resp(b, ok);
      n_tests++; if (!ok || b !== 8'h06) begin n_fail++; $display("FAIL run_resp got %h want 06", b); end
      n_tests++; if (cpu_n_reset !== 1'b1) begin n_fail++; $display("FAIL run_cpu got %b want 1", cpu_n_reset); end
      send_byte(8'hA5);
      send_byte(8'h01);
      wait_resp(b, ok);
      n_tests++; if (!ok || b !== 8'h15) begin n_fail++; $display("FAIL runwr_resp got %h want 15", b); end
      repeat (10) @(negedge clk);
      n_tests++; if (wr_adr.size() != base || busy !== 1'b0) begin n_fail++; $display("FAIL runwr_nomem got %0d writes busy=%b want 0/0", wr_adr.size() - base, busy); end
      send_byte(8'hA5);
      send_byte(8'h04);
      wait_resp(b, ok);
      n_tests++; if (!ok || b !== 8'h06) begin n_fail++; $display("FAIL halt2_resp got %h want 06", b); end
      n_tests++; if (cpu_n_reset !== 1'b0) begin n_fail++; $display("FAIL halt2_cpu got %b want 0", cpu_n_reset); end
   endtask

   task automatic test_timeout;
      logic [7:0] b;
      bit ok;
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h00);
      wait_resp(b, ok);
      n_tests++; if (!ok || b !== 8'h15) begin n_fail++; $display("FAIL tmo_resp got %h want 15", b); end
      @(negedge clk);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle got busy=%b want 0", busy); end
   endtask

   task automatic test_reset_in_wr;
      ack_block = 1'b1;
      send_frame(8'h01, 32'h0003_0000, 1, 8'h00, 1'b0);
      repeat (2) @(negedge clk);
      n_tests++; if (dbg_mem_op !== 1'b1 || dbg_adr !== 32'h0003_0000) begin n_fail++; $display("FAIL wrhold got op=%b adr=%h want 1/00030000", dbg_mem_op, dbg_adr); end
      reset = 1'b1;
      #1;
      n_tests++; if (dbg_mem_op !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b1) begin n_fail++; $display("FAIL wrreset got op=%b busy=%b rdy=%b want 0/0/1", dbg_mem_op, busy, rx_ready); end
      @(negedge clk);
      reset     = 1'b0;
      ack_block = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      tx_ready = 1'b0;
      dbg_ack  = 1'b0;
      dbg_di   = '0;
      test_reset();
      test_write(8'h5A, 8'h06, 1'b0, "wr_ok");
      test_write(8'h00, 8'h15, 1'b1, "wr_badchk");
      test_sync_clears();
      test_count_zero();
      test_verify();
      test_run_halt();
      test_timeout();
      test_reset_in_wr();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
